// File: rtl/rv_mem_resp.sv
// rv_mem_resp: word memory target with fixed wait states and a ready pulse.
// Optional address checking when RV_MEM_ERR_EN is defined.
module rv_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        memrw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              bad;
  logic              mem_we;

  logic [31:0] mem [2**ADDR_W];

`ifdef RV_MEM_ERR_EN
  // Misaligned or out-of-range requests are rejected up front.
  assign bad = (addr[1:0] != 2'b00) ||
               (addr[31:ADDR_W+2] != '0);
`else
  // Without checking, the ignored address bits simply wrap.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign bad = 1'b0;
`endif

  // Next-state, capture and response logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d  = memrw;
          idx_d = addr[ADDR_W+1:2];
          wd_d  = wdata;
          cnt_d = 4'(WAIT_CYCLES);
          if (bad) begin
            state_d = S_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Word array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wd_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
